// File: rtl/sa_result_writeback_if.sv
// SRAM write port of the systolic-array result writeback stage.
// The writeback block is the master; the memory mux or SRAM model is the slave.
// Handshake: there is no ready. The slave commits d to addr on every rising
// clk edge where we=1. mem_req_o marks the cycles in which the master owns the port.
interface sa_result_writeback_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic [DW-1:0] d;
  logic          we;
  logic          mem_req_o;

  modport master (output addr, output d, output we, output mem_req_o);
  modport slave  (input addr, input d, input we, input mem_req_o);
endinterface

// File: rtl/sa_result_writeback.sv
// Result writeback for the systolic array.
// Each tile is a 2x2 output tile. The block captures it, applies optional ReLU,
// and writes its four bytes to consecutive SRAM addresses.
// One job is TILES tiles. A one-cycle done pulse follows the last write.
module sa_result_writeback #(
  parameter int TILES = 4,
  parameter int AW    = 6,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] result_baseaddr,
  input  logic          relu_en,
  input  logic          c_valid,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c21,
  input  logic [DW-1:0] c22,
  sa_result_writeback_if.master mem,
  output logic          busy_o,
  output logic          is_done_o,
  output logic          ovf_o,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TILE = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base_q;
  logic          relu_q;
  logic [3:0]    tile_cnt;
  logic [1:0]    beat_cnt;
  logic [DW-1:0] r_q [4];
  logic [AW-1:0] addr_q;
  logic [DW-1:0] d_q;
  logic          we_q;
  logic          ovf_q;

  logic          start;
  logic          capture;
  logic          last_beat;
  logic          last_tile;
  logic [AW-1:0] tile_off;

  assign start     = (state == IDLE) && en;
  assign capture   = (state == WAIT_TILE) && c_valid;
  assign last_beat = (beat_cnt == 2'd3);
  assign last_tile = (tile_cnt == 4'(TILES - 1));
  assign tile_off  = AW'({tile_cnt, 2'b00});

  // Negative values are zeroed only when the job was started with ReLU on.
  function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] v, input logic on);
    return (on && v[DW-1]) ? '0 : v;
  endfunction

  // Next-state logic. A tile ends after four beats. The job ends after tile TILES-1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (en) state_nxt = WAIT_TILE;
      WAIT_TILE: if (c_valid) state_nxt = WRITE;
      WRITE:     if (last_beat) state_nxt = last_tile ? DONE : WAIT_TILE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Job setup, tile capture, and the registered SRAM beat outputs.
  // The capture edge already presents beat 0, so we is high exactly while in WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q   <= '0;
      relu_q   <= 1'b0;
      tile_cnt <= '0;
      beat_cnt <= '0;
      r_q[0]   <= '0;
      r_q[1]   <= '0;
      r_q[2]   <= '0;
      r_q[3]   <= '0;
      addr_q   <= '0;
      d_q      <= '0;
      we_q     <= 1'b0;
    end else begin
      if (start) begin
        base_q   <= result_baseaddr;
        relu_q   <= relu_en;
        tile_cnt <= '0;
      end
      if (capture) begin
        r_q[0]   <= relu_f(c11, relu_q);
        r_q[1]   <= relu_f(c12, relu_q);
        r_q[2]   <= relu_f(c21, relu_q);
        r_q[3]   <= relu_f(c22, relu_q);
        beat_cnt <= '0;
        we_q     <= 1'b1;
        addr_q   <= base_q + tile_off;
        d_q      <= relu_f(c11, relu_q);
      end
      if (state == WRITE) begin
        if (last_beat) begin
          we_q <= 1'b0;
          if (!last_tile) tile_cnt <= tile_cnt + 4'd1;
        end else begin
          beat_cnt <= beat_cnt + 2'd1;
          addr_q   <= addr_q + AW'(1);
          d_q      <= r_q[beat_cnt + 2'd1];
        end
      end
    end
  end

  // Sticky overflow flag. It sets when a tile arrives while the previous one
  // is still draining. It is cleared only by a new job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              ovf_q <= 1'b0;
    else if (start)                                        ovf_q <= 1'b0;
    else if (c_valid && (state == WRITE || state == DONE)) ovf_q <= 1'b1;
  end

  assign mem.addr      = addr_q;
  assign mem.d         = d_q;
  assign mem.we        = we_q;
  assign mem.mem_req_o = we_q;
  assign busy_o        = (state != IDLE);
  assign is_done_o     = (state == DONE);
  assign ovf_o         = ovf_q;
  assign state_dbg     = state;

endmodule
